// File: rtl/font_render_ctrl_if.sv
// Font renderer bus interface: groups the font ROM address/data bus and the
// valid/ready pixel stream.
//   master (renderer): drives rom_char_code, rom_row, pix_valid, pix_data,
//                      pix_x, pix_y, pix_last; receives rom_font_line, pix_ready.
//   slave  (ROM + pixel sink): the mirror image.
interface font_render_ctrl_if #(
  parameter int IDX_W = 4
);
  logic [7:0]       rom_char_code;
  logic [3:0]       rom_row;
  logic [7:0]       rom_font_line;
  logic             pix_valid;
  logic             pix_ready;
  logic             pix_data;
  logic [IDX_W+2:0] pix_x;
  logic [2:0]       pix_y;
  logic             pix_last;

  modport master (
    output rom_char_code, rom_row,
    input  rom_font_line,
    output pix_valid, pix_data, pix_x, pix_y, pix_last,
    input  pix_ready
  );

  modport slave (
    input  rom_char_code, rom_row,
    output rom_font_line,
    input  pix_valid, pix_data, pix_x, pix_y, pix_last,
    output pix_ready
  );
endinterface

// File: rtl/font_render_ctrl.sv
// font_render_ctrl: walks glyph rows 0-7 and, within each row, every slot of a
// one-line character buffer; fetches each glyph row from an 8x8 font ROM and
// serialises it MSB-first onto a valid/ready pixel stream.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data  character buffer write port
//   start               single-cycle render request (ignored unless idle)
//   busy, done          render in progress / one-cycle completion pulse
//   cursor_pos          underline cursor slot (CURSOR_EN builds only)
//   bus (master)        font ROM bus and pixel stream
// Optional feature: define CURSOR_EN to force row 7 of slot cursor_pos to 8'hFF.
module font_render_ctrl #(
  parameter int NUM_CHARS = 16,
  parameter int IDX_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [7:0]       wr_data,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic [IDX_W-1:0] cursor_pos,
  font_render_ctrl_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_SHIFT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [7:0]       buf_q [NUM_CHARS];
  logic [IDX_W-1:0] char_idx_q, char_idx_d;
  logic [2:0]       row_idx_q, row_idx_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rom_code_q, rom_code_d;
  logic [2:0]       rom_row_q, rom_row_d;
  logic             space_q, space_d;
  logic [7:0]       fetch_code;
  logic [7:0]       capture;
  logic             pix_hs;
  logic             last_char;

  function automatic logic [7:0] sanitise(input logic [7:0] c);
    logic ok;
    ok = !c[7] && ((c >= 8'h30 && c <= 8'h39) || c == 8'h2B || c == 8'h3D || c == 8'h20);
    return ok ? c : 8'h20;
  endfunction

  assign fetch_code = sanitise(buf_q[char_idx_q]);
  assign pix_hs     = (state_q == S_SHIFT) && bus.pix_ready;
  assign last_char  = (char_idx_q == IDX_W'(NUM_CHARS - 1));

  // Space glyphs are blanked regardless of what the ROM returns.
`ifdef CURSOR_EN
  always_comb begin
    capture = space_q ? '0 : bus.rom_font_line;
    if (row_idx_q == 3'd7 && char_idx_q == cursor_pos) capture = '1;
  end
`else
  logic unused_cursor;
  assign unused_cursor = ^cursor_pos;
  always_comb begin
    capture = space_q ? '0 : bus.rom_font_line;
  end
`endif

  // Character buffer: writes are accepted at any time, including mid-render.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CHARS; i++) buf_q[i] <= 8'h20;
    end else if (wr_en && 32'(wr_addr) < NUM_CHARS) begin
      buf_q[wr_addr] <= wr_data;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_FETCH;
      S_FETCH: state_d = S_WAIT;
      S_WAIT:  state_d = S_SHIFT;
      S_SHIFT: if (pix_hs && bit_idx_q == 3'd7)
                 state_d = (last_char && row_idx_q == 3'd7) ? S_DONE : S_FETCH;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next state: counters advance only on the transitions below.
  always_comb begin
    char_idx_d = char_idx_q;
    row_idx_d  = row_idx_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    rom_code_d = rom_code_q;
    rom_row_d  = rom_row_q;
    space_d    = space_q;
    case (state_q)
      S_IDLE: if (start) begin
        char_idx_d = '0;
        row_idx_d  = '0;
        bit_idx_d  = '0;
      end
      S_FETCH: begin
        rom_code_d = fetch_code;
        rom_row_d  = row_idx_q;
        space_d    = (fetch_code == 8'h20);
      end
      S_WAIT: begin
        shift_d   = capture;
        bit_idx_d = '0;
      end
      S_SHIFT: if (pix_hs) begin
        shift_d = {shift_q[6:0], 1'b0};
        if (bit_idx_q == 3'd7) begin
          bit_idx_d = '0;
          if (last_char) begin
            char_idx_d = '0;
            row_idx_d  = (row_idx_q == 3'd7) ? 3'd0 : row_idx_q + 3'd1;
          end else begin
            char_idx_d = char_idx_q + IDX_W'(1);
          end
        end else begin
          bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_idx_q <= '0;
      row_idx_q  <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      rom_code_q <= 8'h20;
      rom_row_q  <= '0;
      space_q    <= 1'b1;
    end else begin
      char_idx_q <= char_idx_d;
      row_idx_q  <= row_idx_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      rom_code_q <= rom_code_d;
      rom_row_q  <= rom_row_d;
      space_q    <= space_d;
    end
  end

  // Outputs. The ROM address is live from the buffer during FETCH (so a write
  // landing just before FETCH is seen) and held from the latched copy after.
  always_comb begin
    bus.rom_char_code = (state_q == S_FETCH) ? fetch_code : rom_code_q;
    bus.rom_row       = {1'b0, (state_q == S_FETCH) ? row_idx_q : rom_row_q};
    bus.pix_valid     = (state_q == S_SHIFT);
    bus.pix_data      = (state_q == S_SHIFT) && shift_q[7];
    bus.pix_x         = {char_idx_q, bit_idx_q};
    bus.pix_y         = row_idx_q;
    bus.pix_last      = (state_q == S_SHIFT) && last_char && row_idx_q == 3'd7 &&
                        bit_idx_q == 3'd7;
    busy              = (state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_SHIFT);
    done              = (state_q == S_DONE);
  end

endmodule
